fetch_decode_elastic_reg: RTL and testbench
===========================================

// Module: fetch_decode_elastic_reg
// PURPOSE
//  Parametrised IF/ID pipeline register with valid/ready handshake, 2-entry skid buffer, stall and flush.
//  Sits between instruction memory read port (fetch) and register file/decoder (decode).
//  Carries instruction word and PC+1; injects NOP bubbles when empty or flushed.
//  Registered in_ready: no combinational path from out_ready to in_ready.
// PARAMETERS
//  INSTR_W   32           instruction word width
//  PC_W      32           width of PC+1 field (full width, not 1 bit)
//  NOP_INSTR 32'h00000000 word driven on instr_d when out_valid=0
//  CNT_W     16           stall counter width (only with FD_PERF_CNT_EN)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous, active-high reset
//  in_valid     in   1       fetch presents instr_f/pc_plus_one_f
//  in_ready     out  1       register can accept this cycle
//  instr_f      in   INSTR_W fetched instruction (IM read data)
//  pc_plus_one_f in  PC_W    PC+1 from fetch
//  flush        in   1       discard all held and incoming entries (branch taken)
//  out_valid    out  1       decode-side entry valid
//  out_ready    in   1       decode consumes entry (0 = stall)
//  instr_d      out  INSTR_W instruction to decode
//  pc_plus_one_d out PC_W    PC+1 to decode
//  stall_cnt    out  CNT_W   stall cycles (only with FD_PERF_CNT_EN)
// BEHAVIOUR
//  Reset (async, rst=1): state EMPTY, out_valid=0, in_ready=1, instr_d=NOP_INSTR, pc_plus_one_d=0, skid cleared.
//  accept = in_valid & in_ready; drain = out_valid & out_ready; all evaluated at posedge clk.
//  States: EMPTY (no entries), ONE (main reg valid), TWO (main + skid valid).
//   EMPTY: accept -> ONE (main <= input).
//   ONE:   accept&drain -> ONE (main <= input); accept&!drain -> TWO (skid <= input);
//          !accept&drain -> EMPTY; else hold.
//   TWO:   in_ready=0; drain -> ONE (main <= skid); else hold.
//  in_ready = (next state != TWO), registered; 1 in EMPTY/ONE, 0 in TWO.
//  Latency: accept at edge N -> out_valid=1 with that entry after edge N. Throughput 1 entry/cycle.
//  Ordering strictly FIFO; no entry dropped or duplicated except on flush.
//  Stall (out_ready=0): outputs stable, bit-exact, until drain.
//  Flush: highest priority; next state EMPTY, both entries invalidated, same-cycle input discarded
//   even if accept=1; in_ready=1 next cycle. instr_d=NOP_INSTR, pc_plus_one_d=0 while empty.
//  Simultaneous flush+drain: drain counts as consumed by decode; state still EMPTY.
//  rst mid-transfer: entries lost, outputs return to reset values immediately.
//  Data fields updated only on load; no arithmetic on PC field (pass-through, full PC_W).
// CONFIGURATION
//  FD_PERF_CNT_EN defined: stall_cnt port present; increments each cycle out_valid&!out_ready;
//   saturates at 2^CNT_W-1; cleared by rst only (flush does not clear).
//  FD_PERF_CNT_EN undefined: no stall_cnt port, no counter logic; behaviour otherwise identical.
// STRUCTURE
//  Package fd_pkg: state encoding (FD_EMPTY=2'd0, FD_ONE=2'd1, FD_TWO=2'd2), default NOP_INSTR constant.
//  Sub-module fd_entry_slot: one {instr, pc} register with load enable and clear; instantiated twice
//   (main, skid). FSM, handshake and counter in top.
// TESTING
//  1. Reset then stream 4 instrs (0x20010005..0x20040008, pc 1..4), out_ready=1 -> each on instr_d 1 cycle later, in order, no bubbles.
//  2. Load A,B with out_ready=0 -> state TWO, in_ready=0; hold 3 cycles -> instr_d=A stable; out_ready=1 -> A then B, in_ready returns 1.
//  3. flush in TWO with in_valid=1 (C) -> next cycle out_valid=0, instr_d=0x00000000, C never appears.
//  4. Assert rst while ONE holding 0x8C220004 -> out_valid=0, instr_d=NOP before next clk edge.
//  5. pc_plus_one_f=32'hFFFFFFFF -> pc_plus_one_d=32'hFFFFFFFF (full width, no truncation).
//  6. FD_PERF_CNT_EN, CNT_W=4: stall 20 cycles -> stall_cnt=15 (saturated); flush -> still 15.

Source files
------------

// File: rtl/fd_pkg.sv
// Shared definitions for the fetch/decode elastic register: FSM encoding and default bubble word.
package fd_pkg;

  typedef enum logic [1:0] {
    FD_EMPTY = 2'd0,
    FD_ONE   = 2'd1,
    FD_TWO   = 2'd2
  } fd_state_e;

  localparam logic [31:0] FD_NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fd_entry_slot.sv
// One {instr, pc} holding register with load enable and synchronous clear (clear wins over load).
module fd_entry_slot
  import fd_pkg::*;
#(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(FD_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [PC_W-1:0]    load_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (clear) begin
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (load) begin
      instr <= load_instr;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_decode_elastic_reg.sv
// IF/ID elastic register: 2-entry skid buffer with registered in_ready, stall and flush.
// Optional stall counter enabled by defining FD_PERF_CNT_EN.
module fetch_decode_elastic_reg
  import fd_pkg::*;
#(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(FD_NOP_INSTR)
`ifdef FD_PERF_CNT_EN
  ,
  parameter int                 CNT_W     = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_f,
  input  logic [PC_W-1:0]    pc_plus_one_f,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_d,
`ifdef FD_PERF_CNT_EN
  output logic [CNT_W-1:0]   stall_cnt,
`endif
  output logic [PC_W-1:0]    pc_plus_one_d
);

  fd_state_e          state, state_next;
  logic               accept, drain;
  logic               main_load, skid_load, main_sel_skid;
  logic [INSTR_W-1:0] main_instr, skid_instr, main_load_instr;
  logic [PC_W-1:0]    main_pc, skid_pc, main_load_pc;

  assign accept    = in_valid & in_ready;
  assign out_valid = (state != FD_EMPTY);
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FD_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != FD_TWO);
    end
  end

  // Flush overrides every transition; the same-cycle input is simply never loaded.
  always_comb begin
    state_next    = state;
    main_load     = 1'b0;
    skid_load     = 1'b0;
    main_sel_skid = 1'b0;
    if (flush) begin
      state_next = FD_EMPTY;
    end else begin
      case (state)
        FD_EMPTY: begin
          if (accept) begin
            state_next = FD_ONE;
            main_load  = 1'b1;
          end
        end
        FD_ONE: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_next = FD_TWO;
            skid_load  = 1'b1;
          end else if (drain) begin
            state_next = FD_EMPTY;
          end
        end
        FD_TWO: begin
          if (drain) begin
            state_next    = FD_ONE;
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
          end
        end
        default: state_next = FD_EMPTY;
      endcase
    end
  end

  assign main_load_instr = main_sel_skid ? skid_instr : instr_f;
  assign main_load_pc    = main_sel_skid ? skid_pc    : pc_plus_one_f;

  fd_entry_slot #(
    .INSTR_W   (INSTR_W),
    .PC_W      (PC_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_main (
    .clk        (clk),
    .rst        (rst),
    .load       (main_load),
    .clear      (flush),
    .load_instr (main_load_instr),
    .load_pc    (main_load_pc),
    .instr      (main_instr),
    .pc         (main_pc)
  );

  fd_entry_slot #(
    .INSTR_W   (INSTR_W),
    .PC_W      (PC_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .clear      (flush),
    .load_instr (instr_f),
    .load_pc    (pc_plus_one_f),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // Main slot keeps its last word after draining to empty, so bubbles are forced here.
  assign instr_d       = out_valid ? main_instr : NOP_INSTR;
  assign pc_plus_one_d = out_valid ? main_pc    : '0;

`ifdef FD_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_elastic_reg.sv
// Scoreboard bench for fetch_decode_elastic_reg; stall counter section active with FD_PERF_CNT_EN.
module tb_fetch_decode_elastic_reg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr_f = '0;
  logic [31:0] pc_plus_one_f = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] instr_d;
  logic [31:0] pc_plus_one_d;
`ifdef FD_PERF_CNT_EN
  logic [3:0]  stall_cnt;
`endif

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_decode_elastic_reg #(
    .INSTR_W   (32),
    .PC_W      (32),
    .NOP_INSTR (32'h0000_0000)
`ifdef FD_PERF_CNT_EN
    ,
    .CNT_W     (4)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instr_f       (instr_f),
    .pc_plus_one_f (pc_plus_one_f),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .instr_d       (instr_d),
`ifdef FD_PERF_CNT_EN
    .stall_cnt     (stall_cnt),
`endif
    .pc_plus_one_d (pc_plus_one_d)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p);
    in_valid      = 1'b1;
    instr_f       = i;
    pc_plus_one_f = p;
    exp_q.push_back('{instr: i, pc: p});
  endtask

  // Monitor: every decode-side transfer must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("exp_available", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("instr_d", 64'(instr_d), 64'(e.instr));
        check("pc_plus_one_d", 64'(pc_plus_one_d), 64'(e.pc));
      end
    end
  end

  logic [31:0] vec [4] = '{32'h20010005, 32'h20020006, 32'h20030007, 32'h20040008};

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_instr_d", 64'(instr_d), 64'h0);
    check("rst_pc_d", 64'(pc_plus_one_d), 64'h0);
    step();
    rst = 1'b0;

    // 1: stream of four with decode always ready
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(vec[i], 32'(i + 1));
      @(negedge clk);
      if (i > 0) check("t1_no_bubble", 64'(out_valid), 64'd1);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_last_valid", 64'(out_valid), 64'd1);
    repeat (3) step();
    check("t1_drained", 64'(exp_q.size()), 64'd0);
    check("t1_empty", 64'(out_valid), 64'd0);

    // 2: fill both entries under stall, hold, then release
    out_ready = 1'b0;
    drive(32'h11110001, 32'd10);
    step();
    drive(32'h22220002, 32'd11);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_in_ready_two", 64'(in_ready), 64'd0);
    check("t2_valid_two", 64'(out_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      check("t2_stall_instr", 64'(instr_d), 64'h11110001);
      check("t2_stall_pc", 64'(pc_plus_one_d), 64'd10);
      check("t2_stall_in_ready", 64'(in_ready), 64'd0);
    end
    step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check("t2_in_ready_back", 64'(in_ready), 64'd1);
    repeat (2) step();
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // 3a: flush while TWO with an incoming word
    out_ready = 1'b0;
    drive(32'h33330003, 32'd20);
    step();
    drive(32'h44440004, 32'd21);
    step();
    drive(32'h55550005, 32'd22);
    flush = 1'b1;
    exp_q.delete();
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t3_flush_valid", 64'(out_valid), 64'd0);
    check("t3_flush_instr", 64'(instr_d), 64'h0);
    check("t3_flush_pc", 64'(pc_plus_one_d), 64'h0);
    check("t3_flush_in_ready", 64'(in_ready), 64'd1);
    step();
    // 3b: flush while ONE with an accepted word in the same cycle
    drive(32'h33330003, 32'd20);
    step();
    drive(32'h55550005, 32'd22);
    flush = 1'b1;
    exp_q.delete();
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t3b_flush_valid", 64'(out_valid), 64'd0);
    check("t3b_flush_instr", 64'(instr_d), 64'h0);
    out_ready = 1'b1;
    repeat (3) step();
    check("t3_nothing_leaked", 64'(out_valid), 64'd0);

    // 4: asynchronous reset while holding one entry
    out_ready = 1'b0;
    drive(32'h8C220004, 32'd30);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("t4_loaded", 64'(instr_d), 64'h8C220004);
    rst = 1'b1;
    #2;
    check("t4_rst_valid", 64'(out_valid), 64'd0);
    check("t4_rst_instr", 64'(instr_d), 64'h0);
    check("t4_rst_pc", 64'(pc_plus_one_d), 64'h0);
    check("t4_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    step();
    rst = 1'b0;

    // 5: full-width PC pass-through
    out_ready = 1'b1;
    drive(32'h0BADF00D, 32'hFFFFFFFF);
    step();
    in_valid = 1'b0;
    repeat (2) step();
    check("t5_drained", 64'(exp_q.size()), 64'd0);

`ifdef FD_PERF_CNT_EN
    // 6: stall counter saturation and flush immunity
    check("t6_cnt_start", 64'(stall_cnt), 64'd0);
    out_ready = 1'b0;
    drive(32'h66660006, 32'd40);
    step();
    in_valid = 1'b0;
    repeat (20) step();
    check("t6_cnt_sat", 64'(stall_cnt), 64'd15);
    flush = 1'b1;
    exp_q.delete();
    step();
    flush = 1'b0;
    step();
    check("t6_cnt_after_flush", 64'(stall_cnt), 64'd15);
    check("t6_flush_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
`endif

    step();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
